// File: rtl/int_div_recon.sv
// Multi-cycle reconstruct-and-check for the integer divider: a_out = yshang*b + yyushu
// via shift-add, plus a legality flag for the remainder (rem_ok = b != 0 && yyushu < b).
module int_div_recon #(
    parameter int unsigned WIDTH = 16
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic [WIDTH-1:0]   yshang,
    input  logic [WIDTH-1:0]   b,
    input  logic [WIDTH-1:0]   yyushu,
    output logic               busy,
    output logic               done,
    output logic [2*WIDTH:0]   a_out,
    output logic               rem_ok
);

    localparam int unsigned PROD_W = 2 * WIDTH;
    localparam int unsigned ACC_W  = 2 * WIDTH + 1;
    localparam int unsigned CNT_W  = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t             r_state;
    logic [PROD_W-1:0]  r_mcand;
    logic [WIDTH-1:0]   r_mplier;
    logic [ACC_W-1:0]   r_acc;
    logic [CNT_W-1:0]   r_cnt;
    logic               r_rem_ok_next;

    logic [ACC_W-1:0]   w_addend;
    logic               w_last;
    logic               w_rem_ok;

    // The multiplicand is shifted in place, so it always equals b << cnt.
    assign w_addend = r_mplier[0] ? {1'b0, r_mcand} : '0;
    assign w_last   = (r_cnt == CNT_W'(WIDTH - 1));
    assign w_rem_ok = (b != '0) && (yyushu < b);

    // busy stays high through the cycle after done so a held start re-accepts every WIDTH+2 cycles.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state       <= S_IDLE;
            r_mcand       <= '0;
            r_mplier      <= '0;
            r_acc         <= '0;
            r_cnt         <= '0;
            r_rem_ok_next <= 1'b0;
            busy          <= 1'b0;
            done          <= 1'b0;
            a_out         <= '0;
            rem_ok        <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        r_mcand       <= PROD_W'(b);
                        r_mplier      <= yshang;
                        r_acc         <= ACC_W'(yyushu);
                        r_rem_ok_next <= w_rem_ok;
                        r_cnt         <= '0;
                        busy          <= 1'b1;
                        r_state       <= S_RUN;
                    end else begin
                        busy <= 1'b0;
                    end
                end
                S_RUN: begin
                    r_acc    <= r_acc + w_addend;
                    r_mplier <= r_mplier >> 1;
                    r_mcand  <= r_mcand << 1;
                    r_cnt    <= r_cnt + CNT_W'(1);
                    if (w_last) begin
                        r_state <= S_DONE;
                    end
                end
                S_DONE: begin
                    a_out   <= r_acc;
                    rem_ok  <= r_rem_ok_next;
                    done    <= 1'b1;
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

endmodule
